if_id_skid_reg: RTL
===================

// Module: if_id_skid_reg
// PURPOSE
//  Parametrised IF->ID pipeline register with valid/ready handshake, an optional skid entry and synchronous flush.
//  Carries PC, instruction and the timer-set sideband from fetch to decode. Decode back-pressure stalls fetch
//  without losing or duplicating instructions. A redirect (branch/trap) squashes the in-flight fetch.
// PARAMETERS
//  PC_W      64             PC width
//  INSTR_W   32             instruction width
//  RESET_PC  64'h8000_0000  out_pc value at reset/flush
//  NOP_INSTR 32'h0000_0013  out_instr value at reset/flush (addi x0,x0,0)
//  SKID      1              1: two-entry slice (main+skid), in_ready registered; 0: single entry
// PORTS
//  clk           in   1        clock
//  rst_n         in   1        asynchronous active-low reset
//  flush         in   1        synchronous squash of all held/incoming entries
//  in_valid      in   1        fetch presents an entry
//  in_ready      out  1        slice can accept an entry this cycle
//  in_pc         in   PC_W     fetch PC
//  in_instr      in   INSTR_W  fetched instruction
//  in_time_set   in   1        timer-set sideband
//  out_valid     out  1        entry presented to decode
//  out_ready     in   1        decode accepts the entry
//  out_pc        out  PC_W     PC to decode
//  out_instr     out  INSTR_W  instruction to decode
//  out_time_set  out  1        sideband to decode
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_pc=RESET_PC, out_instr=NOP_INSTR, out_time_set=0, skid empty.
//    in_ready=1 (SKID=1) or 1 (SKID=0, slice empty). in_valid has no effect while rst_n=0.
//  - Transfer: in_fire = in_valid&in_ready; out_fire = out_valid&out_ready. Latency 1 cycle, throughput 1/cycle.
//  - Strict FIFO order; no drop, no duplicate. Payload and out_valid stable while out_valid&!out_ready.
//  - SKID=1 states: EMPTY (main/skid empty), BUSY (main full), FULL (main+skid full).
//    EMPTY: in_fire -> BUSY (load main).
//    BUSY: in_fire&out_fire -> BUSY (main<=in); in_fire&!out_fire -> FULL (skid<=in);
//          !in_fire&out_fire -> EMPTY; else hold.
//    FULL: out_fire -> BUSY (main<=skid); else hold. in_ready=0 in FULL only.
//    in_ready = !skid_valid, driven from a flop (no comb path from out_ready).
//  - SKID=0: single entry; in_ready = !out_valid | out_ready (comb); simultaneous in/out fire refills main.
//  - flush (highest priority, sync): next cycle out_valid=0, skid empty, out_pc=RESET_PC,
//    out_instr=NOP_INSTR, out_time_set=0, state EMPTY. An in_fire in the flush cycle is discarded;
//    out_fire in the flush cycle still counts as consumed by decode.
//  - Idle payload: when out_valid=0, out_* hold last loaded or reset/flush value; decode must qualify with out_valid.
//  - Reset mid-operation: all entries lost immediately; no partial state survives.
// STRUCTURE
//  - Shared package/defines (rvseed_defines.v): RESET_PC, NOP_INSTR, PC_W, INSTR_W constants.
//  - Payload packed as {time_set, instr, pc}; single flop-based state encoding (main_valid, skid_valid).
//  - No sub-module needed; optional generic pipe_skid_slice if other stage regs reuse it.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> out_valid=0, out_pc=0x80000000, out_instr=0x00000013, out_time_set=0 same cycle.
//  2 Streaming: out_ready=1, in_valid=1, PCs 0x80000000,+4,+8 -> same sequence at out one cycle later, no bubbles.
//  3 Back-pressure: out_ready=0 after 2 accepts -> in_ready=0, out_pc held 0x80000000; release -> 0x80000004 next.
//  4 Flush in FULL: flush=1 with in_valid=1 (pc 0x80000010) -> out_valid=0 next cycle; 0x80000010 never appears.
//  5 Simultaneous fire in BUSY: in_fire&out_fire each cycle -> state stays BUSY, in_ready remains 1.
//  6 SKID=0 build: random valid/ready -> scoreboard order match, in_ready == !out_valid|out_ready each cycle.

Source files
------------

// File: rtl/if_id_skid_reg_pkg.sv
// Shared constants and state type for the IF->ID stage register.
package if_id_skid_reg_pkg;

    localparam int          DEF_PC_W      = 64;
    localparam int          DEF_INSTR_W   = 32;
    localparam logic [63:0] DEF_RESET_PC  = 64'h0000_0000_8000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    // Encoding is {skid_valid, main_valid}, so each bit is directly a
    // registered status flag: bit0 drives out_valid, ~bit1 drives in_ready.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b11
    } slice_state_e;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Valid/ready stream carrying one fetched instruction (pc, instr, time_set).
interface if_id_skid_reg_if
    import if_id_skid_reg_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
);
    logic               valid;
    logic               ready;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               time_set;

    // Producer side of the stream.
    modport master (
        output valid,
        output pc,
        output instr,
        output time_set,
        input  ready
    );

    // Consumer side of the stream.
    modport slave (
        input  valid,
        input  pc,
        input  instr,
        input  time_set,
        output ready
    );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with valid/ready handshake, optional skid entry
// and synchronous flush. SKID=1 gives a registered in_ready (two entries);
// SKID=0 is a single entry whose in_ready depends combinationally on out_ready.
module if_id_skid_reg
    import if_id_skid_reg_pkg::*;
#(
    parameter int                 PC_W      = DEF_PC_W,
    parameter int                 INSTR_W   = DEF_INSTR_W,
    parameter logic [PC_W-1:0]    RESET_PC  = PC_W'(DEF_RESET_PC),
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR),
    parameter bit                 SKID      = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    if_id_skid_reg_if.slave  fetch,
    if_id_skid_reg_if.master decode
);

    localparam int PL_W = PC_W + INSTR_W + 1;
    // Payload layout {time_set, instr, pc}; this is also the idle value after reset/flush.
    localparam logic [PL_W-1:0] RESET_PAYLOAD = {1'b0, NOP_INSTR, RESET_PC};

    logic [PL_W-1:0] in_payload;
    logic [PL_W-1:0] main_q;
    logic            out_valid;
    logic            in_ready;
    logic            in_fire;
    logic            out_fire;

    assign in_payload = {fetch.time_set, fetch.instr, fetch.pc};
    assign in_fire    = fetch.valid & in_ready;
    assign out_fire   = out_valid & decode.ready;

    assign fetch.ready = in_ready;
    assign decode.valid = out_valid;
    assign {decode.time_set, decode.instr, decode.pc} = main_q;

    generate
        if (SKID) begin : g_skid
            slice_state_e    state_reg;
            logic [PL_W-1:0] main_reg;
            logic [PL_W-1:0] skid_reg;

            // Both status outputs come straight from state flops, so there is
            // no combinational path from decode.ready back to fetch.ready.
            assign out_valid = state_reg[0];
            assign in_ready  = ~state_reg[1];
            assign main_q    = main_reg;

            // Slice FSM: main entry feeds decode, skid catches the one extra
            // entry accepted while decode stalls.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= ST_EMPTY;
                    main_reg  <= RESET_PAYLOAD;
                    skid_reg  <= RESET_PAYLOAD;
                end else if (flush) begin
                    state_reg <= ST_EMPTY;
                    main_reg  <= RESET_PAYLOAD;
                end else begin
                    case (state_reg)
                        ST_EMPTY: begin
                            if (in_fire) begin
                                main_reg  <= in_payload;
                                state_reg <= ST_BUSY;
                            end
                        end
                        ST_BUSY: begin
                            if (in_fire && out_fire) begin
                                main_reg <= in_payload;
                            end else if (in_fire) begin
                                skid_reg  <= in_payload;
                                state_reg <= ST_FULL;
                            end else if (out_fire) begin
                                state_reg <= ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (out_fire) begin
                                main_reg  <= skid_reg;
                                state_reg <= ST_BUSY;
                            end
                        end
                        default: begin
                            state_reg <= ST_EMPTY;
                        end
                    endcase
                end
            end
        end else begin : g_single
            logic            valid_reg;
            logic [PL_W-1:0] main_reg;

            assign out_valid = valid_reg;
            assign in_ready  = ~valid_reg | decode.ready;
            assign main_q    = main_reg;

            // Single entry: refill on accept (also when draining the same cycle).
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    main_reg  <= RESET_PAYLOAD;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                    main_reg  <= RESET_PAYLOAD;
                end else if (in_fire) begin
                    valid_reg <= 1'b1;
                    main_reg  <= in_payload;
                end else if (out_fire) begin
                    valid_reg <= 1'b0;
                end
            end
        end
    endgenerate

endmodule
